// File: rtl/tfr_pkg.sv
// Shared types and constants for the transfer-register write-request queue.
package tfr_pkg;

    localparam logic [23:0] TFR_ADDR_RST = 24'hFFFFFF;

    typedef struct packed {
        logic [23:0] addr;
        logic [7:0]  data;
    } tfr_wr_t;

    typedef enum logic {
        WRQ_IDLE,
        WRQ_REQ
    } wrq_state_e;

endpackage

// File: rtl/tfr_wrq_fifo.sv
// Synchronous FIFO of tfr_wr_t with a combinational head; pointers carry an
// extra wrap bit so full and empty are distinguishable.
module tfr_wrq_fifo
    import tfr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       memclk_i,
    input  logic                       nreset_i,
    input  logic                       push_i,
    input  tfr_wr_t                    data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output tfr_wr_t                    head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    tfr_wr_t        mem_q [DEPTH];
    logic [AW:0]    wr_q;
    logic [AW:0]    rd_q;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    // A push into a full queue is allowed when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge memclk_i) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge memclk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/tfr_wrq.sv
// Write-request queue: detects byte writes by address advance, queues them and
// issues them to the SDRAM write port. Optional TFR_WRQ_STATS_EN adds drop_cnt_o.
module tfr_wrq
    import tfr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        memclk_i,
    input  logic        nreset_i,
    input  logic        en_i,
    input  logic [23:0] bus_A_i,
    input  logic [7:0]  bus_D_i,
    output logic        mem_req_o,
    output logic [22:0] mem_A_o,
    output logic [15:0] mem_D_o,
    output logic [1:0]  mem_be_o,
    input  logic        mem_ack_i,
    output logic        busy_o,
    output logic        ovf_o
`ifdef TFR_WRQ_STATS_EN
    ,
    output logic [7:0]  drop_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [23:0] a_q;
    logic [23:0] a_last_q;
    wrq_state_e  state_q, state_d;
    logic [22:0] mem_A_q, mem_A_d;
    logic [15:0] mem_D_q, mem_D_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic        busy_q, busy_d;
    logic        ovf_q;

    logic        new_wr, push, pop, push_ok, drop;
    logic        full, empty;
    tfr_wr_t     head;
    logic [AW:0] count, count_d;

    // Two equal consecutive samples of a fresh address mark one new write.
    assign new_wr  = (bus_A_i == a_q) && (a_q != a_last_q);
    assign push    = new_wr && en_i;
    assign pop     = (state_q == WRQ_REQ) && mem_ack_i;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign count_d = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    assign busy_d  = (count_d != '0);

    tfr_wrq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .memclk_i (memclk_i),
        .nreset_i (nreset_i),
        .push_i   (push),
        .data_i   ('{addr: a_q, data: bus_D_i}),
        .pop_i    (pop),
        .full_o   (full),
        .empty_o  (empty),
        .head_o   (head),
        .count_o  (count)
    );

    always_ff @(posedge memclk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            a_q      <= TFR_ADDR_RST;
            a_last_q <= TFR_ADDR_RST;
        end else begin
            a_q <= bus_A_i;
            if (new_wr) a_last_q <= a_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_A_d  = mem_A_q;
        mem_D_d  = mem_D_q;
        mem_be_d = mem_be_q;
        case (state_q)
            WRQ_IDLE: begin
                if (!empty) begin
                    state_d  = WRQ_REQ;
                    mem_A_d  = head.addr[23:1];
                    mem_D_d  = {head.data, head.data};
                    mem_be_d = head.addr[0] ? 2'b10 : 2'b01;
                end
            end
            WRQ_REQ: begin
                // The entry stays queued until accepted, so payload is stable here.
                if (mem_ack_i) state_d = WRQ_IDLE;
            end
            default: state_d = WRQ_IDLE;
        endcase
    end

    always_ff @(posedge memclk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q  <= WRQ_IDLE;
            mem_A_q  <= '0;
            mem_D_q  <= '0;
            mem_be_q <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_A_q  <= mem_A_d;
            mem_D_q  <= mem_D_d;
            mem_be_q <= mem_be_d;
            busy_q   <= busy_d;
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign mem_req_o = (state_q == WRQ_REQ);
    assign mem_A_o   = mem_A_q;
    assign mem_D_o   = mem_D_q;
    assign mem_be_o  = mem_be_q;
    assign busy_o    = busy_q;
    assign ovf_o     = ovf_q;

`ifdef TFR_WRQ_STATS_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge memclk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tfr_wrq.sv
// Self-checking bench for tfr_wrq: queue-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_tfr_wrq;
    import tfr_pkg::*;

    localparam int DEPTH = 4;

    logic        memclk = 1'b0;
    logic        nreset = 1'b0;
    logic        en = 1'b0;
    logic [23:0] bus_A = 24'hFFFFFF;
    logic [7:0]  bus_D = 8'h00;
    logic        ack = 1'b0;
    logic        mem_req;
    logic [22:0] mem_A;
    logic [15:0] mem_D;
    logic [1:0]  mem_be;
    logic        busy;
    logic        ovf;
`ifdef TFR_WRQ_STATS_EN
    logic [7:0]  drop_cnt;
`endif

    tfr_wrq #(.DEPTH(DEPTH)) dut (
        .memclk_i  (memclk),
        .nreset_i  (nreset),
        .en_i      (en),
        .bus_A_i   (bus_A),
        .bus_D_i   (bus_D),
        .mem_req_o (mem_req),
        .mem_A_o   (mem_A),
        .mem_D_o   (mem_D),
        .mem_be_o  (mem_be),
        .mem_ack_i (ack),
        .busy_o    (busy),
        .ovf_o     (ovf)
`ifdef TFR_WRQ_STATS_EN
        ,
        .drop_cnt_o(drop_cnt)
`endif
    );

    always #5 memclk = ~memclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending writes, in-flight entry stays at the front.
    tfr_wr_t     mq[$];
    logic [23:0] m_aq, m_alast;
    logic        m_req, m_ovf;
    logic [22:0] m_A;
    logic [15:0] m_D;
    logic [1:0]  m_be;
    int          m_drops;
    logic        m_pop, m_start, m_new;

    always @(posedge memclk or negedge nreset) begin
        if (!nreset) begin
            mq.delete();
            m_aq = 24'hFFFFFF; m_alast = 24'hFFFFFF;
            m_req = 0; m_ovf = 0; m_drops = 0;
            m_A = 0; m_D = 0; m_be = 0;
        end else begin
            m_pop   = m_req && ack;
            m_start = !m_req && (mq.size() > 0);
            m_new   = (bus_A == m_aq) && (m_aq != m_alast);
            if (m_pop) begin
                void'(mq.pop_front());
                m_req = 0;
            end
            if (m_start) begin
                m_req = 1;
                m_A   = mq[0].addr[23:1];
                m_D   = {mq[0].data, mq[0].data};
                m_be  = mq[0].addr[0] ? 2'b10 : 2'b01;
            end
            if (m_new) begin
                m_alast = m_aq;
                if (en) begin
                    if (mq.size() < DEPTH) mq.push_back('{addr: m_aq, data: bus_D});
                    else begin
                        m_ovf = 1;
                        if (m_drops < 255) m_drops++;
                    end
                end
            end
            m_aq = bus_A;
        end
    end

    typedef struct packed {
        logic [22:0] a;
        logic [15:0] d;
        logic [1:0]  be;
    } obs_t;
    obs_t log_q[$];
    logic prev_req = 1'b0;

    // Per-cycle compare against the model, and a log of every issued request.
    always @(negedge memclk) begin
        if (!nreset) begin
            prev_req = 1'b0;
        end else begin
            chk("req", mem_req, m_req);
            chk("busy", busy, (mq.size() > 0));
            chk("ovf", ovf, m_ovf);
`ifdef TFR_WRQ_STATS_EN
            chk("drop_cnt", drop_cnt, m_drops);
`endif
            if (m_req) begin
                chk("mem_A", mem_A, m_A);
                chk("mem_D", mem_D, m_D);
                chk("mem_be", mem_be, m_be);
            end
            if (mem_req && !prev_req) begin
                log_q.push_back('{a: mem_A, d: mem_D, be: mem_be});
                $display("req A=%06h D=%04h be=%b", mem_A, mem_D, mem_be);
            end
            prev_req = mem_req;
        end
    end

    // 0: no ack, 1: ack whenever req is seen, 2: random ack
    int ack_mode = 0;
    initial begin
        forever begin
            @(posedge memclk);
            #1;
            case (ack_mode)
                1:       ack = mem_req;
                2:       ack = 1'($urandom_range(0, 1));
                default: ack = 1'b0;
            endcase
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge memclk);
            #1;
        end
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d, input int hold);
        bus_A = a;
        bus_D = d;
        cyc(hold);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    int n0;
    logic [23:0] exp_a;
    int r;

    initial begin
        cyc(3);
        chk("rst_req", mem_req, 0);
        chk("rst_A", mem_A, 0);
        chk("rst_D", mem_D, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        nreset = 1'b1;

        // Idle address after reset must not look like a write.
        cyc(20);
        chk("idle_no_req", log_q.size(), 0);

        // Two directed writes with prompt ack.
        ack_mode = 1;
        en = 1'b1;
        wr(24'h000000, 8'hA5, 4);
        wr(24'h000001, 8'h3C, 4);
        cyc(6);
        chk("two_req_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            chk("w0_A", log_q[0].a, 23'h0);
            chk("w0_be", log_q[0].be, 2'b01);
            chk("w0_D", log_q[0].d, 16'hA5A5);
            chk("w1_A", log_q[1].a, 23'h0);
            chk("w1_be", log_q[1].be, 2'b10);
            chk("w1_D", log_q[1].d, 16'h3C3C);
        end

        // Overflow: stall the controller and push DEPTH+2 writes.
        ack_mode = 0;
        n0 = log_q.size();
        for (int i = 0; i < DEPTH + 2; i++) wr(24'h000010 + 24'(i), 8'h10 + 8'(i), 2);
        cyc(3);
        chk("ovf_set", ovf, 1);
`ifdef TFR_WRQ_STATS_EN
        chk("drop_cnt_2", drop_cnt, 2);
`endif
        chk("stall_one_req", log_q.size() - n0, 1);
        ack_mode = 1;
        cyc(20);
        chk("ovf_delivered", log_q.size() - n0, DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            if (n0 + k < log_q.size()) begin
                exp_a = 24'h000010 + 24'(k);
                chk("ovf_order_A", log_q[n0+k].a, exp_a[23:1]);
                chk("ovf_order_be", log_q[n0+k].be, exp_a[0] ? 2'b10 : 2'b01);
            end
        end
        chk("ovf_sticky", ovf, 1);

        // Disabled capture: only the write after re-enable is issued.
        n0 = log_q.size();
        en = 1'b0;
        wr(24'h000100, 8'h01, 3);
        wr(24'h000101, 8'h02, 3);
        wr(24'h000102, 8'h03, 3);
        en = 1'b1;
        wr(24'h000103, 8'h77, 3);
        cyc(8);
        chk("en_one_req", log_q.size() - n0, 1);
        if (log_q.size() > n0) begin
            chk("en_A", log_q[n0].a, 23'h000081);
            chk("en_be", log_q[n0].be, 2'b10);
            chk("en_D", log_q[n0].d, 16'h7777);
        end

        // Single-cycle glitch to another address.
        n0 = log_q.size();
        wr(24'h000200, 8'h55, 1);
        wr(24'h000103, 8'h77, 8);
        chk("glitch_no_req", log_q.size() - n0, 0);

        // Reset while a request is outstanding with a second entry queued.
        ack_mode = 0;
        wr(24'h000300, 8'h01, 2);
        wr(24'h000301, 8'h02, 2);
        cyc(2);
        chk("pre_rst_req", mem_req, 1);
        n0 = log_q.size();
        nreset = 1'b0;
        bus_A = 24'hFFFFFF;
        #1;
        chk("rst_req_async", mem_req, 0);
        cyc(2);
        nreset = 1'b1;
        cyc(10);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_no_req", log_q.size() - n0, 0);

        // Address wrap is an ordinary advance.
        ack_mode = 1;
        n0 = log_q.size();
        wr(24'hFFFFFE, 8'hE1, 3);
        wr(24'hFFFFFF, 8'hE2, 3);
        wr(24'h000000, 8'hE3, 3);
        cyc(8);
        chk("wrap_reqs", log_q.size() - n0, 3);

        // Randomized traffic against the model.
        ack_mode = 2;
        for (int it = 0; it < 500; it++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 4)      wr(bus_A + 24'd1, 8'($urandom), int'($urandom_range(1, 3)));
            else if (r <= 6) wr(24'($urandom), 8'($urandom), int'($urandom_range(1, 4)));
            else if (r == 7) begin
                exp_a = bus_A;
                wr(24'($urandom), 8'($urandom), 1);
                bus_A = exp_a;
                cyc(1);
            end
            else if (r == 8) begin
                en = ~en;
                cyc(1);
            end
            else cyc(int'($urandom_range(1, 5)));
        end
        ack_mode = 1;
        cyc(40);
        chk("drain_busy", busy, 0);
        chk("drain_req", mem_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tfr_wrq.md
# tfr_wrq

Write-request queue downstream of the support-CPU memory transfer register block. It watches the transfer address/data pair in the memory clock domain and detects each new byte write by an address advance. It queues the address/data pairs and issues them one at a time to the SDRAM controller's write port over a req/ack handshake, using 16-bit word addressing and a byte mask.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- memclk_i  in  1  memory-domain clock; the only clock
- nreset_i  in  1  reset, asynchronous, active-low
- en_i  in  1  capture enable; low = support CPU does not own SDRAM, writes are discarded
- bus_A_i  in  24  transfer byte address, already registered in memclk domain
- bus_D_i  in  8  transfer data byte, quasi-static (bus-clock domain, stable around address advance)
- mem_req_o  out  1  write request to SDRAM controller
- mem_A_o  out  23  word address = byte address [23:1]
- mem_D_o  out  16  data byte replicated on both lanes
- mem_be_o  out  2  byte enable; 2'b01 if byte addr[0]=0, 2'b10 if 1
- mem_ack_i  in  1  controller accepted the request this cycle
- busy_o  out  1  queue non-empty or request outstanding
- ovf_o  out  1  sticky: a write was dropped because the queue was full

## Operation
- Detector: a_q <= bus_A_i every cycle; a_last holds the last accepted address.
- New write = (bus_A_i == a_q) && (a_q != a_last); this requires two equal consecutive samples, which filters CDC skew.
- On a new write: a_last <= a_q. If en_i=1, push {a_q, bus_D_i}.
- If en_i=0: a_last still tracks, nothing is pushed, no backlog builds.
- Queue full and no pop in the same cycle: entry dropped, ovf_o <= 1.
- Full with a pop in the same cycle: push accepted.
- Pop and push in the same cycle on a non-empty queue: both happen, count unchanged.
- FSM IDLE: if queue is non-empty, load the head into mem_A_o/mem_D_o/mem_be_o, assert mem_req_o and go to REQ; the pop happens on acceptance.
- FSM REQ: hold req and all payload stable until mem_ack_i=1 is sampled. Then pop the head, deassert req and go to IDLE.
- mem_ack_i while in IDLE: ignored.
- No timeout: REQ waits indefinitely.
- ovf_o clears only on reset.
- Address wrap FFFFFF->000000 is a normal advance.

## Timing
- Reset values:
  - a_q = a_last = 24'hFFFFFF, matching the upstream post-reset address, so there is no spurious push.
  - Queue empty, FSM IDLE.
  - mem_req_o = 0, mem_A_o = 0, mem_D_o = 0, mem_be_o = 0, busy_o = 0, ovf_o = 0.
- Reset asserted mid-request: req drops immediately (async) and the queue is flushed.
- Latency, with edge E0 the first edge sampling a new bus_A_i:
  - Push at E1.
  - mem_req_o high after E2 if the FSM is IDLE and the queue was empty.
- Ack sampled at edge Ek: req low after Ek, minimum one IDLE cycle, next req earliest after Ek+1. Throughput is at most one write per 2 cycles.
- busy_o is registered and high from the cycle after the push until the cycle after the final ack.

## Configuration
- TFR_WRQ_STATS_EN defined: adds output drop_cnt_o[7:0].
  - Counts dropped writes, saturating at 8'hFF, reset 0.
  - Increments on the same condition that sets ovf_o.
- Undefined: no port, no counter logic; ovf_o still present.

## Structure
- Shared package tfr_pkg holds:
  - typedef tfr_wr_t {logic [23:0] addr; logic [7:0] data;}
  - FSM enum {WRQ_IDLE, WRQ_REQ}
  - constant TFR_ADDR_RST = 24'hFFFFFF
- Sub-module tfr_wrq_fifo: synchronous FIFO of tfr_wr_t.
  - Parameter DEPTH.
  - Signals push/pop/full/empty/head.
  - Async active-low reset.
  - Pointers one bit wider than log2(DEPTH) for full/empty detection.

## Test plan
- Reset, then hold bus_A_i=FFFFFF for 20 cycles -> no push, mem_req_o stays 0.
- en_i=1, bus_A_i=000000 then 000001 with D=A5 then 3C, ack 1 cycle after each req -> two requests:
  - mem_A_o=0, be=01, D=A5A5
  - mem_A_o=0, be=10, D=3C3C
- Stall mem_ack_i low; push DEPTH+2 writes -> DEPTH entries delivered in order after ack resumes, ovf_o=1, drop_cnt_o=2 (with TFR_WRQ_STATS_EN).
- en_i=0 during 3 address advances, then en_i=1 and 1 advance -> exactly one request, for the last address.
- bus_A_i glitches for a single cycle to a different value and returns -> no push.
- Assert nreset_i while in REQ with 2 queued entries -> req low immediately; after release busy_o=0 and no request is issued.
